// File: rtl/rv32i_cpu.sv
// Single-cycle RV32I core: fetch, decode, execute, memory and writeback in one clock.
// Register file and both memories expose an array named mem for hierarchical preload/probe.

module rv32i_mem #(
    parameter int DEPTH = 16384,
    parameter int AW    = 14
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [0:DEPTH-1];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
endmodule

module rv32i_rf (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] mem [0:31];

    assign rd1 = mem[ra1];
    assign rd2 = mem[ra2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (we && wa != 5'd0) begin
            mem[wa] <= wd;
        end
    end
endmodule

module rv32i_cpu #(
    parameter int          CPU_CLOCK_FREQ = 50_000_000,
    parameter logic [31:0] RESET_PC       = 32'h1000_0000
) (
    input  logic clk,
    input  logic rst,
    input  logic bp_enable,
    input  logic serial_in,
    output logic serial_out
);
    localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_JALR = 7'h67,
                           OP_BR  = 7'h63, OP_LD    = 7'h03, OP_ST  = 7'h23, OP_IMM  = 7'h13,
                           OP_REG = 7'h33;

    logic [31:0] pc, pc_next, pc_plus4, instr;
    logic [31:0] rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] alu_b, alu_y, addr, ld_word, ld_val, wb, st_data, jalr_t;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [3:0]  st_we;
    logic        rf_we, br_take;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic        unused_ok;

    assign serial_out = 1'b1;
    assign unused_ok  = ^{bp_enable, serial_in, addr[31:16]};

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    rv32i_mem imem (.clk(clk), .we(4'b0), .addr(pc[15:2]), .wdata(32'b0), .rdata(instr));

    rv32i_rf rf (
        .clk(clk), .rst(rst), .ra1(instr[19:15]), .ra2(instr[24:20]), .wa(instr[11:7]),
        .we(rf_we), .wd(wb), .rd1(rs1_v), .rd2(rs2_v)
    );

    // Stores are held off while rst is high since dmem itself has no reset.
    rv32i_mem dmem (.clk(clk), .we(rst ? 4'b0 : st_we), .addr(addr[15:2]), .wdata(st_data), .rdata(ld_word));

    assign pc_plus4 = pc + 32'd4;
    assign addr     = rs1_v + ((opcode == OP_ST) ? imm_s : imm_i);
    assign jalr_t   = (rs1_v + imm_i) & ~32'd1;
    assign alu_b    = (opcode == OP_REG) ? rs2_v : imm_i;

    always_comb begin
        alu_y = '0;
        case (f3)
            3'd0: alu_y = (opcode == OP_REG && instr[30]) ? rs1_v - alu_b : rs1_v + alu_b;
            3'd1: alu_y = rs1_v << alu_b[4:0];
            3'd2: alu_y = {31'b0, $signed(rs1_v) < $signed(alu_b)};
            3'd3: alu_y = {31'b0, rs1_v < alu_b};
            3'd4: alu_y = rs1_v ^ alu_b;
            3'd5: alu_y = instr[30] ? 32'($signed(rs1_v) >>> alu_b[4:0]) : rs1_v >> alu_b[4:0];
            3'd6: alu_y = rs1_v | alu_b;
            3'd7: alu_y = rs1_v & alu_b;
            default: alu_y = '0;
        endcase
    end

    always_comb begin
        br_take = 1'b0;
        case (f3)
            3'd0: br_take = rs1_v == rs2_v;
            3'd1: br_take = rs1_v != rs2_v;
            3'd4: br_take = $signed(rs1_v) <  $signed(rs2_v);
            3'd5: br_take = $signed(rs1_v) >= $signed(rs2_v);
            3'd6: br_take = rs1_v <  rs2_v;
            3'd7: br_take = rs1_v >= rs2_v;
            default: br_take = 1'b0;
        endcase
    end

    assign ld_byte = ld_word[{addr[1:0], 3'b000} +: 8];
    assign ld_half = addr[1] ? ld_word[31:16] : ld_word[15:0];

    always_comb begin
        ld_val = ld_word;
        case (f3)
            3'd0: ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'd1: ld_val = {{16{ld_half[15]}}, ld_half};
            3'd4: ld_val = {24'b0, ld_byte};
            3'd5: ld_val = {16'b0, ld_half};
            default: ld_val = ld_word;
        endcase
    end

    // Replicated store data lands in the right lane once byte enables pick it.
    always_comb begin
        st_we   = 4'b0;
        st_data = rs2_v;
        if (opcode == OP_ST) begin
            case (f3)
                3'd0: begin st_we = 4'b0001 << addr[1:0]; st_data = {4{rs2_v[7:0]}}; end
                3'd1: begin st_we = addr[1] ? 4'b1100 : 4'b0011; st_data = {2{rs2_v[15:0]}}; end
                3'd2: st_we = 4'b1111;
                default: st_we = 4'b0;
            endcase
        end
    end

    always_comb begin
        rf_we   = 1'b0;
        wb      = alu_y;
        pc_next = pc_plus4;
        case (opcode)
            OP_LUI:   begin rf_we = 1'b1; wb = imm_u; end
            OP_AUIPC: begin rf_we = 1'b1; wb = pc + imm_u; end
            OP_JAL:   begin rf_we = 1'b1; wb = pc_plus4; pc_next = pc + imm_j; end
            OP_JALR:  begin rf_we = 1'b1; wb = pc_plus4; pc_next = jalr_t; end
            OP_BR:    if (br_take) pc_next = pc + imm_b;
            OP_LD:    begin rf_we = 1'b1; wb = ld_val; end
            OP_IMM, OP_REG: rf_we = 1'b1;
            default:  rf_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc <= RESET_PC;
        else     pc <= pc_next;
    end
endmodule

// File: tb/tb_rv32i_cpu.sv
// Directed program bench for rv32i_cpu: preload imem/dmem, run, probe rf/dmem/pc.

module tb_rv32i_cpu;
    localparam logic [31:0] RESET_PC = 32'h1000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst, bp_enable, serial_in, serial_out;
    int   n_chk = 0, n_fail = 0;

    rv32i_cpu #(.CPU_CLOCK_FREQ(50_000_000), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .bp_enable(bp_enable), .serial_in(serial_in), .serial_out(serial_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Hold core in reset and wipe the low program/data area.
    task automatic prog_begin();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 64; i++)  dut.imem.mem[i] = NOP;
        for (int i = 0; i < 128; i++) dut.dmem.mem[i] = 32'h0;
    endtask

    task automatic go(input int cycles);
        @(negedge clk);
        rst = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        int n;
        logic [31:0] orv;
        rst = 1'b1; bp_enable = 1'b0; serial_in = 1'b1;

        // Reset release and first-instruction latency
        prog_begin();
        dut.imem.mem[0] = 32'h00E00713;
        dut.dmem.mem[0] = 32'h00E00713;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pc", dut.pc, RESET_PC);
        check("rst_x14", dut.rf.mem[14], 32'd0);
        check("serial_rst", {31'b0, serial_out}, 32'd1);
        rst = 1'b0;
        n = 0;
        while (dut.rf.mem[14] !== 32'd14 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("x14", dut.rf.mem[14], 32'd14);
        check("x14_lat", {31'b0, n <= 2}, 32'd1);
        check("dmem0_kept", dut.dmem.mem[0], 32'h00E00713);

        // Branches: not taken then taken
        prog_begin();
        dut.imem.mem[0] = 32'h1F400093; // addi x1,x0,500
        dut.imem.mem[1] = 32'h06400113; // addi x2,x0,100
        dut.imem.mem[2] = 32'h00208463; // beq x1,x2,+8
        dut.imem.mem[3] = 32'h00200A13; // addi x20,x0,2
        dut.imem.mem[4] = 32'h00108463; // beq x1,x1,+8
        dut.imem.mem[5] = 32'h00700A93; // addi x21,x0,7 (skipped)
        dut.imem.mem[6] = 32'h00900B13; // addi x22,x0,9
        go(8);
        check("x1", dut.rf.mem[1], 32'd500);
        check("x2", dut.rf.mem[2], 32'd100);
        check("beq_nt_x20", dut.rf.mem[20], 32'd2);
        check("beq_t_x21", dut.rf.mem[21], 32'd0);
        check("beq_t_x22", dut.rf.mem[22], 32'd9);

        // Loads and stores across lanes
        prog_begin();
        dut.dmem.mem[65] = 32'h8000_80F0;
        dut.imem.mem[0] = 32'h123452B7; // lui x5,0x12345
        dut.imem.mem[1] = 32'h67828293; // addi x5,x5,0x678
        dut.imem.mem[2] = 32'h10502023; // sw x5,0x100(x0)
        dut.imem.mem[3] = 32'h10100303; // lb x6,0x101(x0)
        dut.imem.mem[4] = 32'h10205383; // lhu x7,0x102(x0)
        dut.imem.mem[5] = 32'h10400403; // lb x8,0x104(x0)
        dut.imem.mem[6] = 32'h10404483; // lbu x9,0x104(x0)
        dut.imem.mem[7] = 32'h10601503; // lh x10,0x106(x0)
        dut.imem.mem[8] = 32'h105002A3; // sb x5,0x105(x0)
        dut.imem.mem[9] = 32'h10501523; // sh x5,0x10A(x0)
        go(12);
        check("x5", dut.rf.mem[5], 32'h12345678);
        check("sw_m64", dut.dmem.mem[64], 32'h12345678);
        check("lb_x6", dut.rf.mem[6], 32'h56);
        check("lhu_x7", dut.rf.mem[7], 32'h1234);
        check("lb_neg_x8", dut.rf.mem[8], 32'hFFFF_FFF0);
        check("lbu_x9", dut.rf.mem[9], 32'h0000_00F0);
        check("lh_neg_x10", dut.rf.mem[10], 32'hFFFF_8000);
        check("sb_m65", dut.dmem.mem[65], 32'h8000_78F0);
        check("sh_m66", dut.dmem.mem[66], 32'h5678_0000);

        // Shifts and compares
        prog_begin();
        dut.imem.mem[0] = 32'hFFF00093; // addi x1,x0,-1
        dut.imem.mem[1] = 32'h4040D113; // srai x2,x1,4
        dut.imem.mem[2] = 32'h01C0D193; // srli x3,x1,28
        dut.imem.mem[3] = 32'h00103233; // sltu x4,x0,x1
        dut.imem.mem[4] = 32'h0000A2B3; // slt x5,x1,x0
        dut.imem.mem[5] = 32'h40100333; // sub x6,x0,x1
        dut.imem.mem[6] = 32'h0060C433; // xor x8,x1,x6
        go(9);
        check("srai_x2", dut.rf.mem[2], 32'hFFFF_FFFF);
        check("srli_x3", dut.rf.mem[3], 32'h0000_000F);
        check("sltu_x4", dut.rf.mem[4], 32'd1);
        check("slt_x5", dut.rf.mem[5], 32'd1);
        check("sub_x6", dut.rf.mem[6], 32'd1);
        check("xor_x8", dut.rf.mem[8], 32'hFFFF_FFFE);

        // JAL / JALR
        prog_begin();
        dut.imem.mem[0] = 32'h00C000EF; // jal x1,+12
        dut.imem.mem[1] = 32'h00300493; // addi x9,x0,3
        dut.imem.mem[2] = 32'h00500513; // addi x10,x0,5
        dut.imem.mem[3] = 32'h00008067; // jalr x0,0(x1)
        go(1);
        check("jal_x1", dut.rf.mem[1], 32'h1000_0004);
        check("jal_pc", dut.pc, 32'h1000_000C);
        @(negedge clk);
        check("jalr_pc", dut.pc, 32'h1000_0004);
        check("jalr_x0", dut.rf.mem[0], 32'd0);
        @(negedge clk);
        check("after_jalr_x9", dut.rf.mem[9], 32'd3);
        check("skipped_x10", dut.rf.mem[10], 32'd0);

        // x0 immutability, loop, async reset mid-run
        prog_begin();
        dut.imem.mem[0] = 32'h00100013; // addi x0,x0,1
        dut.imem.mem[1] = 32'h00118193; // addi x3,x3,1
        dut.imem.mem[2] = 32'hFFDFF06F; // jal x0,-4
        go(10);
        check("x0_zero", dut.rf.mem[0], 32'd0);
        check("loop_x3", dut.rf.mem[3], 32'd5);
        check("serial_run", {31'b0, serial_out}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_pc", dut.pc, RESET_PC);
        orv = '0;
        for (int i = 0; i < 32; i++) orv |= dut.rf.mem[i];
        check("async_regs", orv, 32'd0);
        check("serial_async", {31'b0, serial_out}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
